// File: rtl/uart_line_collector.sv
// ---------------------------------------------------------------------------
// uart_line_collector
//
// Gathers bytes from NCH simulation UART byte streams into one line buffer
// per channel. CR (0x0D) or LF (0x0A) ends a line. Completed lines are
// granted round-robin and streamed out one byte per valid/ready handshake.
// Each byte is tagged with its source channel, a last-byte flag, an
// empty-line flag and a truncation flag. Bytes that arrive while a channel
// is waiting for, or busy with, output are dropped and counted.
//
// Ports:
//   theclk      - clock
//   theresetn   - asynchronous active-low reset, released synchronously
//   in_data     - NCH bytes, channel c at [8c+7:8c]
//   in_valid    - per-channel one-cycle byte strobe (no backpressure)
//   out_valid   - output byte valid
//   out_ready   - sink accepts the current byte
//   out_data    - line byte (0x00 for an empty-line marker)
//   out_chan    - source channel of the current line
//   out_last    - final byte of the line, or sole marker of an empty line
//   out_empty   - line has zero length
//   out_trunc   - line overflowed DEPTH; held for every byte of that line
//   drop_count  - per-channel 16-bit saturating dropped-byte counters
// ---------------------------------------------------------------------------
module uart_line_collector #(
   parameter int NCH        = 3,
   parameter int DEPTH      = 256,
   parameter bit EMIT_EMPTY = 1'b0,
   parameter int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              theclk,
   input  logic              theresetn,
   input  logic [NCH*8-1:0]  in_data,
   input  logic [NCH-1:0]    in_valid,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_data,
   output logic [CW-1:0]     out_chan,
   output logic              out_last,
   output logic              out_empty,
   output logic              out_trunc,
   output logic [NCH*16-1:0] drop_count
);

   localparam int AW = $clog2(DEPTH);
   // Fill index and length must hold the value DEPTH itself.
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {CH_FILL, CH_PEND, CH_DRAIN} ch_state_e;
   typedef enum logic [1:0] {O_IDLE, O_LOAD, O_STREAM} out_state_e;

   // Per-channel status flattened so the output side can index it by grant.
   logic [NCH-1:0]    pend_vec;
   logic [NCH-1:0]    trunc_vec;
   logic [NCH*LW-1:0] len_flat;
   logic [NCH*8-1:0]  rdata_flat;

   // Output-side controls seen by every channel.
   logic              grant;
   logic [CW-1:0]     grant_sel;
   logic              line_done;
   logic [CW-1:0]     gnt_q, gnt_d;
   logic [LW-1:0]     rd_q, rd_d;
   logic [AW-1:0]     rd_addr;

   // ------------------------------------------------------------------------
   // Per-channel collectors
   // ------------------------------------------------------------------------
   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      ch_state_e   st_q, st_d;
      logic [LW-1:0] idx_q, idx_d;
      logic [LW-1:0] len_q, len_d;
      logic        trunc_q, trunc_d;
      logic [15:0] drop_q, drop_d;
      logic [7:0]  byte_w;
      logic        vld;
      logic        is_term;
      logic        my_grant;
      logic        my_done;
      logic        wr_en;
      logic [7:0]  mem [DEPTH];
      logic [7:0]  rdata_q;

      assign byte_w   = in_data[8*gi +: 8];
      assign vld      = in_valid[gi];
      assign is_term  = (byte_w == 8'h0D) || (byte_w == 8'h0A);
      assign my_grant = grant && (grant_sel == CW'(gi));
      assign my_done  = line_done && (gnt_q == CW'(gi));

      always_comb begin
         st_d    = st_q;
         idx_d   = idx_q;
         len_d   = len_q;
         trunc_d = trunc_q;
         drop_d  = drop_q;
         wr_en   = 1'b0;
         // Anything arriving outside FILL is lost; count it, saturating.
         if (vld && (st_q != CH_FILL) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
         end
         case (st_q)
            CH_FILL: begin
               if (vld) begin
                  if (is_term) begin
                     // A bare terminator is swallowed unless empty lines
                     // are wanted; this collapses CR LF pairs.
                     if ((idx_q != '0) || EMIT_EMPTY) begin
                        len_d = idx_q;
                        st_d  = CH_PEND;
                     end
                  end else if (idx_q == LW'(DEPTH)) begin
                     trunc_d = 1'b1;
                  end else begin
                     wr_en = 1'b1;
                     idx_d = idx_q + LW'(1);
                  end
               end
            end
            CH_PEND: begin
               if (my_grant) begin
                  st_d = CH_DRAIN;
               end
            end
            CH_DRAIN: begin
               if (my_done) begin
                  st_d    = CH_FILL;
                  idx_d   = '0;
                  trunc_d = 1'b0;
               end
            end
            default: st_d = CH_FILL;
         endcase
      end

      always_ff @(posedge theclk or negedge theresetn) begin
         if (!theresetn) begin
            st_q    <= CH_FILL;
            idx_q   <= '0;
            len_q   <= '0;
            trunc_q <= 1'b0;
            drop_q  <= '0;
         end else begin
            st_q    <= st_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            trunc_q <= trunc_d;
            drop_q  <= drop_d;
         end
      end

      // Line buffer: plain RAM, no reset, registered read. The read address
      // is the output side's next read pointer so data is ready in time.
      always_ff @(posedge theclk) begin
         if (wr_en) begin
            mem[idx_q[AW-1:0]] <= byte_w;
         end
         rdata_q <= mem[rd_addr];
      end

      assign pend_vec[gi]           = (st_q == CH_PEND);
      assign trunc_vec[gi]          = trunc_q;
      assign len_flat[gi*LW +: LW]  = len_q;
      assign rdata_flat[gi*8 +: 8]  = rdata_q;
      assign drop_count[gi*16 +: 16] = drop_q;
   end

   // ------------------------------------------------------------------------
   // Round-robin search: first pending channel at or after ptr, wrapping.
   // ------------------------------------------------------------------------
   logic [CW-1:0] ptr_q, ptr_d;
   logic          found;
   logic [CW-1:0] sel;

   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < NCH; i++) begin
         int c;
         c = int'(ptr_q) + i;
         if (c >= NCH) begin
            c = c - NCH;
         end
         if (!found && pend_vec[c]) begin
            found = 1'b1;
            sel   = CW'(c);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output FSM. LOAD is the cycle in which the first buffer byte is read,
   // so out_valid rises two cycles after the terminator edge.
   // ------------------------------------------------------------------------
   out_state_e    o_q, o_d;
   logic [LW-1:0] len_sel;
   logic [7:0]    rdata_sel;
   logic          is_last;

   assign len_sel   = len_flat[gnt_q*LW +: LW];
   assign rdata_sel = rdata_flat[gnt_q*8 +: 8];
   assign is_last   = (len_sel == '0) || (rd_q == len_sel - LW'(1));

   always_comb begin
      o_d   = o_q;
      gnt_d = gnt_q;
      ptr_d = ptr_q;
      rd_d  = rd_q;
      grant = 1'b0;
      case (o_q)
         O_IDLE: begin
            if (found) begin
               grant = 1'b1;
               gnt_d = sel;
               rd_d  = '0;
               o_d   = O_LOAD;
            end
         end
         O_LOAD: begin
            rd_d = '0;
            o_d  = O_STREAM;
         end
         O_STREAM: begin
            if (out_ready) begin
               if (is_last) begin
                  ptr_d = (gnt_q == CW'(NCH - 1)) ? '0 : gnt_q + CW'(1);
                  o_d   = O_IDLE;
               end else begin
                  rd_d = rd_q + LW'(1);
               end
            end
         end
         default: o_d = O_IDLE;
      endcase
   end

   always_ff @(posedge theclk or negedge theresetn) begin
      if (!theresetn) begin
         o_q   <= O_IDLE;
         gnt_q <= '0;
         ptr_q <= '0;
         rd_q  <= '0;
      end else begin
         o_q   <= o_d;
         gnt_q <= gnt_d;
         ptr_q <= ptr_d;
         rd_q  <= rd_d;
      end
   end

   assign grant_sel = sel;
   assign rd_addr   = rd_d[AW-1:0];
   assign line_done = out_valid && out_ready && is_last;

   // All outputs derive from registers and are forced to zero outside STREAM.
   assign out_valid = (o_q == O_STREAM);
   assign out_data  = (out_valid && (len_sel != '0)) ? rdata_sel : 8'h00;
   assign out_chan  = out_valid ? gnt_q : '0;
   assign out_last  = out_valid && is_last;
   assign out_empty = out_valid && (len_sel == '0);
   assign out_trunc = out_valid && trunc_vec[gnt_q];

endmodule
